register_status_unit: RTL

- Register-status (Qi) table and CDB write-back agent for the Tomasulo core.
- Issue logic sends rename requests (rd, tag) to this block; the block also answers source-operand tag lookups for the reservation stations.
- It snoops the common data bus (CDB). When a broadcast tag matches a register's pending tag, it retires that register and drives the regfile write port.
- It sits on the receiving end of the CDB, opposite the functional units and memory unit that drive it.

---
 rtl/tomasulo_pkg.sv | 24 ++
 rtl/register_status_unit_if.sv | 54 +++++
 rtl/register_status_unit_lookup.sv | 41 ++++
 rtl/register_status_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: register/tag/data widths, tag and register-status types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tomasulo_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int TAG_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;

    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [REG_ADDR_W:0]   cnt_t;

    // Tag 0 means "value is in the regfile, no producer outstanding".
    localparam tag_t NO_TAG   = '0;
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    typedef struct packed {
        tag_t Qi;
    } RegisterStat_t;

endpackage

// File: rtl/register_status_unit_if.sv
// Bundle of issue, source-lookup, CDB and regfile-write signals around the register-status unit.
// Latency: n/a (wiring only).
// Backpressure: none; every request is accepted in the cycle it is presented.
interface register_status_unit_if;
    import tomasulo_pkg::*;

    logic      issue_valid;
    reg_addr_t issue_rd;
    tag_t      issue_tag;

    reg_addr_t src1_addr;
    reg_addr_t src2_addr;
    logic      src1_busy;
    logic      src2_busy;
    tag_t      src1_tag;
    tag_t      src2_tag;
    logic      src1_fwd;
    logic      src2_fwd;
    data_t     src1_fwd_data;
    data_t     src2_fwd_data;

    logic      cdb_valid;
    tag_t      cdb_tag;
    data_t     cdb_data;

    logic      Reg_writevalid;
    reg_addr_t Reg_writeaddr;
    data_t     Reg_writedata;
    cnt_t      busy_count;
    logic      alias_err;

    // Issue/reservation-station/CDB side.
    modport master (
        output issue_valid, issue_rd, issue_tag,
        output src1_addr, src2_addr,
        output cdb_valid, cdb_tag, cdb_data,
        input  src1_busy, src2_busy, src1_tag, src2_tag,
        input  src1_fwd, src2_fwd, src1_fwd_data, src2_fwd_data,
        input  Reg_writevalid, Reg_writeaddr, Reg_writedata,
        input  busy_count, alias_err
    );

    // Register-status unit side.
    modport slave (
        input  issue_valid, issue_rd, issue_tag,
        input  src1_addr, src2_addr,
        input  cdb_valid, cdb_tag, cdb_data,
        output src1_busy, src2_busy, src1_tag, src2_tag,
        output src1_fwd, src2_fwd, src1_fwd_data, src2_fwd_data,
        output Reg_writevalid, Reg_writeaddr, Reg_writedata,
        output busy_count, alias_err
    );

endinterface

// File: rtl/register_status_unit_lookup.sv
// Per-source operand lookup: busy/tag from Qi, with forwarding from the live CDB or the pending regfile write.
// Latency: purely combinational.
// Backpressure: none.
module reg_status_lookup
    import tomasulo_pkg::*;
(
    input  reg_addr_t addr,
    input  tag_t      qi,
    input  logic      cdb_valid,
    input  tag_t      cdb_tag,
    input  data_t     cdb_data,
    input  logic      wr_vld,
    input  reg_addr_t wr_addr,
    input  data_t     wr_data,
    output logic      busy,
    output tag_t      tag,
    output logic      fwd,
    output data_t     fwd_data
);

    // Priority: x0, live CDB hit, still pending, landing regfile write, plain regfile read.
    always_comb begin
        busy     = 1'b0;
        tag      = NO_TAG;
        fwd      = 1'b0;
        fwd_data = '0;
        if (addr == '0) begin
            busy = 1'b0;
        end else if (qi != NO_TAG && cdb_valid && qi == cdb_tag) begin
            fwd      = 1'b1;
            fwd_data = cdb_data;
        end else if (qi != NO_TAG) begin
            busy = 1'b1;
            tag  = qi;
        end else if (wr_vld && wr_addr == addr) begin
            fwd      = 1'b1;
            fwd_data = wr_data;
        end
    end

endmodule

// File: rtl/register_status_unit.sv
// Register-status (Qi) table: renames destinations, retires them on CDB tag match and drives the regfile write port.
// Latency: rename/retire take effect on the next edge; regfile write is registered, 1 cycle after the CDB broadcast.
// Backpressure: none; issue and CDB inputs are always accepted, lookups are combinational.
module register_status_unit
    import tomasulo_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    register_status_unit_if.slave   rsu
);

    RegisterStat_t qi_q [NUM_REGS];
    RegisterStat_t qi_d [NUM_REGS];
    logic          wr_vld_q,  wr_vld_d;
    reg_addr_t     wr_addr_q, wr_addr_d;
    data_t         wr_data_q, wr_data_d;
    cnt_t          busy_cnt_q, busy_cnt_d;
    logic          alias_q,   alias_d;

    logic          rename_hit;
    logic          cdb_hit;
    logic          match_seen;

    // Next-state table: rename beats retire; lowest non-renamed match gets the regfile write.
    always_comb begin
        qi_d       = qi_q;
        wr_vld_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_cnt_d = '0;
        alias_d    = alias_q;
        rename_hit = 1'b0;
        cdb_hit    = 1'b0;
        match_seen = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            rename_hit = rsu.issue_valid && (rsu.issue_rd == reg_addr_t'(r))
                         && (rsu.issue_tag != NO_TAG);
            cdb_hit    = rsu.cdb_valid && (qi_q[r].Qi != NO_TAG)
                         && (qi_q[r].Qi == rsu.cdb_tag);
            if (cdb_hit) begin
                if (match_seen) begin
                    alias_d = 1'b1;
                end
                match_seen = 1'b1;
            end
            if (rename_hit) begin
                qi_d[r].Qi = rsu.issue_tag;
            end else if (cdb_hit) begin
                qi_d[r].Qi = NO_TAG;
                if (!wr_vld_d) begin
                    wr_vld_d  = 1'b1;
                    wr_addr_d = reg_addr_t'(r);
                    wr_data_d = rsu.cdb_data;
                end
            end
            if (qi_d[r].Qi != NO_TAG) begin
                busy_cnt_d = busy_cnt_d + CNT_ONE;
            end
        end
    end

    // State registers; reset drops all renames and any write in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                qi_q[r] <= '0;
            end
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_cnt_q <= '0;
            alias_q    <= 1'b0;
        end else begin
            qi_q       <= qi_d;
            wr_vld_q   <= wr_vld_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_cnt_q <= busy_cnt_d;
            alias_q    <= alias_d;
        end
    end

    assign rsu.Reg_writevalid = wr_vld_q;
    assign rsu.Reg_writeaddr  = wr_addr_q;
    assign rsu.Reg_writedata  = wr_data_q;
    assign rsu.busy_count     = busy_cnt_q;
    assign rsu.alias_err      = alias_q;

    reg_status_lookup u_lookup_src1 (
        .addr      (rsu.src1_addr),
        .qi        (qi_q[rsu.src1_addr].Qi),
        .cdb_valid (rsu.cdb_valid),
        .cdb_tag   (rsu.cdb_tag),
        .cdb_data  (rsu.cdb_data),
        .wr_vld    (wr_vld_q),
        .wr_addr   (wr_addr_q),
        .wr_data   (wr_data_q),
        .busy      (rsu.src1_busy),
        .tag       (rsu.src1_tag),
        .fwd       (rsu.src1_fwd),
        .fwd_data  (rsu.src1_fwd_data)
    );

    reg_status_lookup u_lookup_src2 (
        .addr      (rsu.src2_addr),
        .qi        (qi_q[rsu.src2_addr].Qi),
        .cdb_valid (rsu.cdb_valid),
        .cdb_tag   (rsu.cdb_tag),
        .cdb_data  (rsu.cdb_data),
        .wr_vld    (wr_vld_q),
        .wr_addr   (wr_addr_q),
        .wr_data   (wr_data_q),
        .busy      (rsu.src2_busy),
        .tag       (rsu.src2_tag),
        .fwd       (rsu.src2_fwd),
        .fwd_data  (rsu.src2_fwd_data)
    );

endmodule
